// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read- and write-side controllers.
//   - w_state_t : write controller states (IDLE=0, WAIT_FULL=1, PUSH=2)
//   - r_state_t : read controller states (WAIT/EMPTY/POP)
//   - FIFO_DEEP / FIFO_DATA_W : default address width and data width
package fifo_pkg;

   localparam int unsigned FIFO_DEEP   = 8;
   localparam int unsigned FIFO_DATA_W = 8;

   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_WAIT_FULL = 2'd1,
      W_PUSH      = 2'd2
   } w_state_t;

   typedef enum logic [1:0] {
      R_WAIT  = 2'd0,
      R_EMPTY = 2'd1,
      R_POP   = 2'd2
   } r_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit wrapping pointer shared by both FIFO controllers.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the pointer to 0
//   inc   : advance the pointer by one (wraps 2^W-1 -> 0)
//   ptr   : current pointer value
module fifo_ptr #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + W'(1);
   end

endmodule

// File: rtl/fifo_w_ctrl.sv
// fifo_w_ctrl: write-side FIFO controller. Accepts producer words over a
// valid/ready handshake into a one-word hold register and pushes them into
// the FIFO memory at a wrapping write address, stalling while Full is high.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   en      : producer valid, din carries a word
//   din     : producer data
//   ready   : controller accepts din this cycle
//   Full    : FIFO full status
//   push    : memory write strobe, one word per asserted cycle
//   wdata   : memory write data (the hold register)
//   address : memory write address for the current push
module fifo_w_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DEEP   = FIFO_DEEP,
   parameter int unsigned DATA_W = FIFO_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic              ready,
   input  logic              Full,
   output logic              push,
   output logic [DATA_W-1:0] wdata,
   output logic [DEEP-1:0]   address
);

   w_state_t          state;
   logic [DATA_W-1:0] hold;

   // push/ready are Mealy on Full so a word can move every cycle; gating with
   // rst_n keeps both low for the whole time reset is asserted.
   always_comb begin
      push  = rst_n && (state == W_PUSH) && !Full;
      ready = rst_n && ((state == W_IDLE) || ((state == W_PUSH) && !Full));
   end

   assign wdata = hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= W_IDLE;
         hold  <= '0;
      end else begin
         unique case (state)
            W_IDLE: begin
               if (en) begin
                  hold  <= din;
                  state <= Full ? W_WAIT_FULL : W_PUSH;
               end
            end
            W_WAIT_FULL: begin
               if (!Full)
                  state <= W_PUSH;
            end
            W_PUSH: begin
               if (Full)
                  state <= W_WAIT_FULL;
               else if (en)
                  hold <= din;   // held word leaves this edge, refill in place
               else
                  state <= W_IDLE;
            end
            default: state <= W_IDLE;
         endcase
      end
   end

   fifo_ptr #(
      .W(DEEP)
   ) u_ptr (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (push),
      .ptr  (address)
   );

endmodule

// File: tb/tb_fifo_w_ctrl.sv
module tb_fifo_w_ctrl;

   localparam int unsigned DEEP   = 3;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 1 << DEEP;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [DATA_W-1:0] din;
   logic              ready;
   logic              Full;
   logic              push;
   logic [DATA_W-1:0] wdata;
   logic [DEEP-1:0]   address;

   fifo_w_ctrl #(
      .DEEP  (DEEP),
      .DATA_W(DATA_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .din    (din),
      .ready  (ready),
      .Full   (Full),
      .push   (push),
      .wdata  (wdata),
      .address(address)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int          cyc   = 0;
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      chk_en <= 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Behavioural model: one held word. A held word may go out in a cycle only
   // if Full is low now and was low at the previous edge (a stall costs one
   // settle cycle after Full falls).
   logic              m_held;
   logic [DATA_W-1:0] m_hold;
   logic              m_prev_full;
   int unsigned       m_addr;
   logic              exp_push, exp_ready;

   assign exp_push  = rst_n && m_held && !m_prev_full && !Full;
   assign exp_ready = rst_n && (!m_held || exp_push);

   always @(posedge clk) begin
      m_prev_full <= Full;
      if (!rst_n) begin
         m_held <= 1'b0;
         m_hold <= '0;
         m_addr <= 0;
      end else begin
         if (exp_push) m_addr <= (m_addr + 1) % DEPTH;
         if (en && exp_ready) begin
            m_held <= 1'b1;
            m_hold <= din;
         end else if (exp_push) begin
            m_held <= 1'b0;
         end
      end
   end

   typedef struct {
      int                cyc;
      logic [DEEP-1:0]   a;
      logic [DATA_W-1:0] d;
   } push_rec_t;
   push_rec_t push_log[$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", ready, exp_ready);
         chk("push", push, exp_push);
         chk("address", address, m_addr[DEEP-1:0]);
         chk("wdata", wdata, m_hold);
         if (push === 1'b1) push_log.push_back('{cyc, address, wdata});
      end
   end

   task automatic step(input logic r, input logic e, input logic f, input logic [DATA_W-1:0] d);
      @(posedge clk);
      #1;
      rst_n = r;
      en    = e;
      Full  = f;
      din   = d;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      Full  = 1'b0;
      din   = 8'hAA;

      // 1. reset
      step(1'b0, 1'b1, 1'b0, 8'hAA);
      step(1'b0, 1'b1, 1'b0, 8'hAA);
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_push", push, 0);
      chk("rst_address", address, 0);
      chk("rst_wdata", wdata, 0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("rel_ready", ready, 1);

      // 2+3. streaming 10 words, wraps after address 7
      push_log.delete();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("stream_count", push_log.size(), 10);
      for (int i = 0; i < 10 && i < push_log.size(); i++) begin
         chk("stream_addr", push_log[i].a, i % 8);
         chk("stream_data", push_log[i].d, 8'h10 + i);
         chk("stream_back2back", push_log[i].cyc, push_log[0].cyc + i);
      end

      // 4. Full stall in the PUSH cycle, held for 3 cycles
      push_log.delete();
      step(1'b1, 1'b1, 1'b0, 8'h55);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 8'h99);
         @(negedge clk);
         chk("stall_push", push, 0);
         chk("stall_ready", ready, 0);
      end
      step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("settle_push", push, 0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("resume_push", push, 1);
      chk("resume_wdata", wdata, 8'h55);
      chk("resume_addr", address, 2);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("stall_count", push_log.size(), 1);

      // 5. Full at acceptance from IDLE
      push_log.delete();
      step(1'b1, 1'b1, 1'b1, 8'h66);
      @(negedge clk);
      chk("idle_full_ready", ready, 1);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      @(negedge clk);
      chk("park_ready", ready, 0);
      chk("park_wdata", wdata, 8'h66);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("park_settle_push", push, 0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("park_push", push, 1);
      chk("park_push_data", wdata, 8'h66);
      chk("park_push_addr", address, 3);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("park_count", push_log.size(), 1);

      // 6. reset while parked in WAIT_FULL
      push_log.delete();
      step(1'b1, 1'b1, 1'b1, 8'h77);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("mid_rst_count", push_log.size(), 0);
      chk("mid_rst_addr", address, 0);
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_wdata", wdata, 0);

      // random traffic, per-cycle checks from the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(49) != 0,
              $urandom_range(9) < 7,
              $urandom_range(9) < 3,
              8'($urandom));
      end
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
